// File: rtl/phasemeter_acq_pll.sv
// Decimated-rate phase-locking controller for the LIA/CORDIC phasemeter.
// Sweeps the NCO frequency until signal appears, then closes a runtime-gain PI loop.
// Declares lock after a run of in-window samples, recovers on sustained signal loss,
// and produces an unwrapped phase while locked.
module phasemeter_acq_pll #(
  parameter int ACCUM_WIDTH = 32,
  parameter int PHASE_BITS  = 16,
  parameter int MAG_BITS    = 14,
  parameter int UNWRAP_BITS = 48,
  parameter int LOCK_WIN    = 1024,
  parameter int LOSS_COUNT  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [PHASE_BITS-1:0]  s_phase_tdata,
  input  logic                          s_phase_tvalid,
  input  logic [MAG_BITS-1:0]           s_mag_tdata,
  input  logic                          cfg_enable,
  input  logic [ACCUM_WIDTH-1:0]        cfg_center,
  input  logic [ACCUM_WIDTH-1:0]        cfg_step,
  input  logic [ACCUM_WIDTH-1:0]        cfg_span,
  input  logic [4:0]                    cfg_kp,
  input  logic [4:0]                    cfg_ki,
  input  logic                          cfg_sign,
  input  logic [MAG_BITS-1:0]           cfg_mag_thresh,
  input  logic [15:0]                   cfg_lock_count,
  output logic [ACCUM_WIDTH-1:0]        m_freq_tdata,
  output logic                          m_freq_tvalid,
  output logic signed [UNWRAP_BITS-1:0] m_phase_tdata,
  output logic                          m_phase_tvalid,
  output logic [1:0]                    state,
  output logic                          locked,
  output logic [7:0]                    lost_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SWEEP   = 2'd1;
  localparam logic [1:0] ST_ACQUIRE = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  // NOTE: the error is shifted by up to 31 places, so the PI sums run in a domain wide
  // enough to hold the exact result; saturation then clamps instead of wrapping.
  localparam int WW = ACCUM_WIDTH + PHASE_BITS + 34;
  localparam int OW = ACCUM_WIDTH + 2;
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-ACCUM_WIDTH+1){1'b0}}, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-ACCUM_WIDTH+1){1'b1}}, {(ACCUM_WIDTH-1){1'b0}}};

  logic signed [ACCUM_WIDTH-1:0] integ;
  logic signed [ACCUM_WIDTH-1:0] offset;
  logic [15:0]                   good_cnt;
  logic [LW-1:0]                 loss_cnt;
  logic                          unwrap_init;
  logic signed [PHASE_BITS-1:0]  prev_phase;

  logic signed [WW-1:0]          err_w;
  logic signed [WW-1:0]          integ_sum;
  logic signed [WW-1:0]          act_sum;
  logic signed [ACCUM_WIDTH-1:0] integ_new;
  logic signed [ACCUM_WIDTH-1:0] act;
  logic [ACCUM_WIDTH-1:0]        freq_pi;
  logic [ACCUM_WIDTH-1:0]        freq_sweep;
  logic [ACCUM_WIDTH-1:0]        neg_span;
  logic signed [OW-1:0]          off_sum;
  logic                          off_wrap;
  logic [PHASE_BITS:0]           phase_abs;
  logic                          in_win;
  logic                          mag_ok;
  logic [16:0]                   cnt_inc;
  logic [16:0]                   lock_target;
  logic                          lock_reached;
  logic signed [PHASE_BITS-1:0]  phase_d;
  logic signed [UNWRAP_BITS-1:0] unwrap_next;

  // Clamp a wide signed value into the signed ACCUM_WIDTH range.
  function automatic logic signed [ACCUM_WIDTH-1:0] sat_accum(input logic signed [WW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[ACCUM_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[ACCUM_WIDTH-1:0];
    else                  return x[ACCUM_WIDTH-1:0];
  endfunction

  assign locked = (state == ST_LOCKED);

  // Per-sample datapath: PI update, sweep step, lock window and phase difference.
  always_comb begin
    // NOTE: every signal here is fully assigned on each evaluation, so no latch is inferred.
    err_w        = cfg_sign ? -WW'(s_phase_tdata) : WW'(s_phase_tdata);
    integ_sum    = WW'(integ) + (err_w <<< cfg_ki);
    integ_new    = sat_accum(integ_sum);
    act_sum      = WW'(integ_new) + (err_w <<< cfg_kp);
    act          = sat_accum(act_sum);
    freq_pi      = cfg_center + $unsigned(act);
    freq_sweep   = cfg_center + $unsigned(offset);
    neg_span     = -cfg_span;
    off_sum      = OW'(offset) + $signed({2'b00, cfg_step});
    off_wrap     = off_sum > $signed({2'b00, cfg_span});
    phase_abs    = s_phase_tdata[PHASE_BITS-1] ? -{s_phase_tdata[PHASE_BITS-1], s_phase_tdata}
                                               :  {s_phase_tdata[PHASE_BITS-1], s_phase_tdata};
    in_win       = phase_abs < (PHASE_BITS+1)'(LOCK_WIN);
    mag_ok       = s_mag_tdata >= cfg_mag_thresh;
    cnt_inc      = {1'b0, good_cnt} + 17'd1;
    lock_target  = (cfg_lock_count == 16'd0) ? 17'd1 : {1'b0, cfg_lock_count};
    lock_reached = cnt_inc >= lock_target;
    phase_d      = s_phase_tdata - prev_phase;
    unwrap_next  = m_phase_tdata + UNWRAP_BITS'(phase_d);
  end

  // Controller state, loop registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      integ          <= '0;
      offset         <= '0;
      good_cnt       <= '0;
      loss_cnt       <= '0;
      unwrap_init    <= 1'b0;
      prev_phase     <= '0;
      m_freq_tdata   <= '0;
      m_freq_tvalid  <= 1'b0;
      m_phase_tdata  <= '0;
      m_phase_tvalid <= 1'b0;
      lost_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
      m_freq_tvalid  <= 1'b0;
      m_phase_tvalid <= 1'b0;
      if (!cfg_enable) begin
        state        <= ST_IDLE;
        integ        <= '0;
        offset       <= '0;
        good_cnt     <= '0;
        loss_cnt     <= '0;
        unwrap_init  <= 1'b0;
        m_freq_tdata <= cfg_center;
      end else begin
        case (state)
          ST_IDLE: begin
            state        <= ST_SWEEP;
            offset       <= $signed(neg_span);
            m_freq_tdata <= cfg_center;
          end
          ST_SWEEP: if (s_phase_tvalid) begin
            m_freq_tvalid <= 1'b1;
            m_freq_tdata  <= freq_sweep;
            if (mag_ok) begin
              state    <= ST_ACQUIRE;
              integ    <= offset;
              good_cnt <= '0;
            end else begin
              offset <= off_wrap ? $signed(neg_span) : off_sum[ACCUM_WIDTH-1:0];
            end
          end
          ST_ACQUIRE: if (s_phase_tvalid) begin
            m_freq_tvalid <= 1'b1;
            m_freq_tdata  <= freq_pi;
            integ         <= integ_new;
            if (!mag_ok) begin
              // Signal gone: resume the sweep from where it stopped.
              state    <= ST_SWEEP;
              good_cnt <= '0;
            end else if (!in_win) begin
              good_cnt <= '0;
            end else if (lock_reached) begin
              state       <= ST_LOCKED;
              good_cnt    <= '0;
              loss_cnt    <= '0;
              unwrap_init <= 1'b1;
            end else begin
              good_cnt <= cnt_inc[15:0];
            end
          end
          default: if (s_phase_tvalid) begin
            // LOCKED: the first sample seeds the unwrapper at zero.
            m_freq_tvalid  <= 1'b1;
            m_freq_tdata   <= freq_pi;
            m_phase_tvalid <= 1'b1;
            m_phase_tdata  <= unwrap_init ? '0 : unwrap_next;
            prev_phase     <= s_phase_tdata;
            unwrap_init    <= 1'b0;
            if (mag_ok) begin
              loss_cnt <= '0;
              integ    <= integ_new;
            end else if (loss_cnt == LW'(LOSS_COUNT - 1)) begin
              state    <= ST_SWEEP;
              integ    <= '0;
              offset   <= $signed(neg_span);
              loss_cnt <= '0;
              if (lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
            end else begin
              loss_cnt <= loss_cnt + LW'(1);
              integ    <= integ_new;
            end
          end
        endcase
      end
    end
  end

endmodule
